// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem arbiter: request owner, read-return tag and
// the width of the G starvation counter.
package dmem_arb_pkg;

    localparam int STARVE_CNT_W = 4;
    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = '1;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_G = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_P};

endpackage

// File: rtl/arb_tag_pipe.sv
// RD_LAT-deep shift register of read tags; its output marks which port owns
// the dmem q word currently on the bus.
module arb_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [RD_LAT];

    // NOTE: the tag stages are reset (unlike a data RAM) so a read in flight at
    // reset can never raise rvalid afterwards; non-blocking keeps the shift order-independent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= TAG_IDLE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the processor data port (P) and the
// game engine (G): one grant per clock, tagged read returns, bounded G starvation.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 3,
    parameter int G_WR_EN    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              g_req,
    input  logic              g_wren,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_gnt,
    output logic              g_rvalid,
    output logic [DATA_W-1:0] g_rdata,
    output logic              g_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic G_WR_OK = (G_WR_EN != 0);
    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(STARVE_LIM);

    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic g_err_q, g_err_d;
    logic g_wins;
    tag_t tag_push, tag_out;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        g_wins    = (starve_q >= LIM);
        // Grants are gated by reset so nothing is issued while the arbiter is held.
        p_gnt     = reset & p_req & (~g_req | ~g_wins);
        g_gnt     = reset & g_req & (~p_req | g_wins);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        if (p_gnt) begin
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
            mem_wren  = p_wren;
        end else if (g_gnt) begin
            mem_addr  = g_addr;
            mem_wdata = g_wdata;
            mem_wren  = g_wren & G_WR_OK;
        end
        g_err_d        = g_gnt & g_wren & ~G_WR_OK;
        tag_push.valid = (p_gnt & ~p_wren) | (g_gnt & ~g_wren);
        tag_push.owner = g_gnt ? OWN_G : OWN_P;
    end

    always_comb begin
        starve_d = starve_q;
        if (g_gnt) begin
            starve_d = '0;
        end else if (g_req && starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
            g_err_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            g_err_q  <= g_err_d;
        end
    end

    arb_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clock (clock),
        .reset (reset),
        .tag_i (tag_push),
        .tag_o (tag_out)
    );

    assign p_rvalid = tag_out.valid && (tag_out.owner == OWN_P);
    assign g_rvalid = tag_out.valid && (tag_out.owner == OWN_G);
    assign p_rdata  = mem_q;
    assign g_rdata  = mem_q;
    assign g_err    = g_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (default, G writes disabled,
// RD_LAT=2) share one stimulus bus, each backed by its own behavioural dmem.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p_req, p_wren, g_req, g_wren;
    logic [11:0] p_addr, g_addr;
    logic [31:0] p_wdata, g_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance A: RD_LAT=1, G_WR_EN=1
    logic        a_p_gnt, a_p_rvalid, a_g_gnt, a_g_rvalid, a_g_err, a_mem_wren;
    logic [31:0] a_p_rdata, a_g_rdata, a_mem_wdata, a_mem_q;
    logic [11:0] a_mem_addr;
    logic [31:0] mem_a [4096];

    // Instance B: RD_LAT=1, G_WR_EN=0
    logic        b_p_gnt, b_p_rvalid, b_g_gnt, b_g_rvalid, b_g_err, b_mem_wren;
    logic [31:0] b_p_rdata, b_g_rdata, b_mem_wdata, b_mem_q;
    logic [11:0] b_mem_addr;
    logic [31:0] mem_b [4096];

    // Instance C: RD_LAT=2, G_WR_EN=1
    logic        c_p_gnt, c_p_rvalid, c_g_gnt, c_g_rvalid, c_g_err, c_mem_wren;
    logic [31:0] c_p_rdata, c_g_rdata, c_mem_wdata, c_mem_q, c_q1;
    logic [11:0] c_mem_addr;
    logic [31:0] mem_c [4096];

    dmem_arbiter #(.RD_LAT(1), .STARVE_LIM(3), .G_WR_EN(1)) dut_a (
        .clock(clk), .reset(rst_n),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(a_p_gnt), .p_rvalid(a_p_rvalid), .p_rdata(a_p_rdata),
        .g_req(g_req), .g_wren(g_wren), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(a_g_gnt), .g_rvalid(a_g_rvalid), .g_rdata(a_g_rdata), .g_err(a_g_err),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wren(a_mem_wren), .mem_q(a_mem_q)
    );

    dmem_arbiter #(.RD_LAT(1), .STARVE_LIM(3), .G_WR_EN(0)) dut_b (
        .clock(clk), .reset(rst_n),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(b_p_gnt), .p_rvalid(b_p_rvalid), .p_rdata(b_p_rdata),
        .g_req(g_req), .g_wren(g_wren), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(b_g_gnt), .g_rvalid(b_g_rvalid), .g_rdata(b_g_rdata), .g_err(b_g_err),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wren(b_mem_wren), .mem_q(b_mem_q)
    );

    dmem_arbiter #(.RD_LAT(2), .STARVE_LIM(3), .G_WR_EN(1)) dut_c (
        .clock(clk), .reset(rst_n),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(c_p_gnt), .p_rvalid(c_p_rvalid), .p_rdata(c_p_rdata),
        .g_req(g_req), .g_wren(g_wren), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(c_g_gnt), .g_rvalid(c_g_rvalid), .g_rdata(c_g_rdata), .g_err(c_g_err),
        .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_wren(c_mem_wren), .mem_q(c_mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port syncrams: registered read, write on the same edge.
    always @(posedge clk) begin
        if (a_mem_wren) mem_a[a_mem_addr] <= a_mem_wdata;
        a_mem_q <= mem_a[a_mem_addr];
        if (b_mem_wren) mem_b[b_mem_addr] <= b_mem_wdata;
        b_mem_q <= mem_b[b_mem_addr];
        if (c_mem_wren) mem_c[c_mem_addr] <= c_mem_wdata;
        c_q1    <= mem_c[c_mem_addr];
        c_mem_q <= c_q1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_inputs(input logic pr, input logic pw, input logic [11:0] pa,
                              input logic [31:0] pd, input logic gr, input logic gw,
                              input logic [11:0] ga, input logic [31:0] gd);
        p_req = pr; p_wren = pw; p_addr = pa; p_wdata = pd;
        g_req = gr; g_wren = gw; g_addr = ga; g_wdata = gd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if ({a_p_gnt, a_g_gnt, a_p_rvalid, a_g_rvalid, a_mem_wren, a_g_err} !== 6'b0)
            $display("FAIL reset_outputs: got %b want 000000",
                     {a_p_gnt, a_g_gnt, a_p_rvalid, a_g_rvalid, a_mem_wren, a_g_err});
        else n_pass++;
        n_checks++;
        if (a_mem_addr !== 12'h000)
            $display("FAIL reset_mem_addr: got %h want 000", a_mem_addr);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({a_p_gnt, a_g_gnt} !== 2'b10)
            $display("FAIL release_first_grant: got p,g=%b want 10", {a_p_gnt, a_g_gnt});
        else n_pass++;
        tick();
    endtask

    task automatic test_write_read();
        set_inputs(1'b1, 1'b1, 12'h0AB, 32'h1234_5678, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        n_checks++;
        if ({a_p_gnt, a_mem_wren, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 12'h0AB, 32'h1234_5678})
            $display("FAIL p_write_issue: got gnt=%b wren=%b addr=%h data=%h want 1 1 0ab 12345678",
                     a_p_gnt, a_mem_wren, a_mem_addr, a_mem_wdata);
        else n_pass++;
        tick();
        set_inputs(1'b1, 1'b0, 12'h0AB, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        n_checks++;
        if ({a_p_gnt, a_mem_wren, a_g_rvalid, a_p_rvalid} !== 4'b1000)
            $display("FAIL p_read_issue: got gnt,wren,grv,prv=%b want 1000",
                     {a_p_gnt, a_mem_wren, a_g_rvalid, a_p_rvalid});
        else n_pass++;
        tick();
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        n_checks++;
        if ({a_p_rvalid, a_g_rvalid, a_p_rdata} !== {1'b1, 1'b0, 32'h1234_5678})
            $display("FAIL p_read_return: got prv=%b grv=%b data=%h want 1 0 12345678",
                     a_p_rvalid, a_g_rvalid, a_p_rdata);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if ({a_p_rvalid, a_p_gnt, a_mem_wren} !== 3'b000)
            $display("FAIL idle_after_read: got prv,gnt,wren=%b want 000",
                     {a_p_rvalid, a_p_gnt, a_mem_wren});
        else n_pass++;
    endtask

    task automatic test_contention();
        logic eg;
        // A lone G grant clears any starvation count left from earlier cycles.
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h100, 32'h0);
        #1;
        n_checks++;
        if ({a_p_gnt, a_g_gnt} !== 2'b01)
            $display("FAIL g_only_grant: got p,g=%b want 01", {a_p_gnt, a_g_gnt});
        else n_pass++;
        tick();
        for (int i = 0; i < 8; i++) begin
            set_inputs(1'b1, 1'b0, 12'h101, 32'h0, 1'b1, 1'b0, 12'h102, 32'h0);
            #1;
            eg = (i == 3) || (i == 7);
            n_checks++;
            if ({a_p_gnt, a_g_gnt} !== {~eg, eg})
                $display("FAIL contention_grant_%0d: got p,g=%b want %b", i,
                         {a_p_gnt, a_g_gnt}, {~eg, eg});
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 7; k++) begin
            if (k == 6)
                set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
            else if (k % 2 == 0)
                set_inputs(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
            else
                set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
            #1;
            if (k > 0) begin
                if ((k - 1) % 2 == 0) begin
                    n_checks++;
                    if ({a_p_rvalid, a_g_rvalid, a_p_rdata} !== {2'b10, 32'h11})
                        $display("FAIL alt_p_return_%0d: got prv=%b grv=%b data=%h want 1 0 00000011",
                                 k, a_p_rvalid, a_g_rvalid, a_p_rdata);
                    else n_pass++;
                end else begin
                    n_checks++;
                    if ({a_p_rvalid, a_g_rvalid, a_g_rdata} !== {2'b01, 32'h22})
                        $display("FAIL alt_g_return_%0d: got prv=%b grv=%b data=%h want 0 1 00000022",
                                 k, a_p_rvalid, a_g_rvalid, a_g_rdata);
                    else n_pass++;
                end
            end
            tick();
        end
    endtask

    task automatic test_g_write_disabled();
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h3FF, 32'h0000_DEAD);
        #1;
        n_checks++;
        if ({b_g_gnt, b_mem_wren, b_g_err} !== 3'b100)
            $display("FAIL gwr_off_issue: got gnt,wren,err=%b want 100", {b_g_gnt, b_mem_wren, b_g_err});
        else n_pass++;
        n_checks++;
        if ({a_g_gnt, a_mem_wren} !== 2'b11)
            $display("FAIL gwr_on_issue: got gnt,wren=%b want 11", {a_g_gnt, a_mem_wren});
        else n_pass++;
        tick();
        set_inputs(1'b1, 1'b0, 12'h3FF, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        n_checks++;
        if ({b_g_err, a_g_err, b_p_gnt} !== 3'b101)
            $display("FAIL gwr_err_pulse: got b_err,a_err,p_gnt=%b want 101", {b_g_err, a_g_err, b_p_gnt});
        else n_pass++;
        tick();
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        n_checks++;
        if ({b_g_err, b_p_rvalid, b_p_rdata} !== {2'b01, 32'hCAFE_0000})
            $display("FAIL gwr_old_value: got err=%b prv=%b data=%h want 0 1 cafe0000",
                     b_g_err, b_p_rvalid, b_p_rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_inflight();
        // Baseline: a G read on the RD_LAT=2 instance returns two clocks later.
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h040, 32'h0);
        #1;
        tick();
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        n_checks++;
        if (c_g_rvalid !== 1'b0)
            $display("FAIL lat2_early: got grv=%b want 0", c_g_rvalid);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if ({c_g_rvalid, c_g_rdata} !== {1'b1, 32'h44})
            $display("FAIL lat2_return: got grv=%b data=%h want 1 00000044", c_g_rvalid, c_g_rdata);
        else n_pass++;
        tick();
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h040, 32'h0);
        #1;
        n_checks++;
        if (c_g_gnt !== 1'b1)
            $display("FAIL inflight_grant: got g_gnt=%b want 1", c_g_gnt);
        else n_pass++;
        tick();
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({c_g_rvalid, c_p_rvalid} !== 2'b00)
                $display("FAIL inflight_discard_%0d: got grv,prv=%b want 00", i, {c_g_rvalid, c_p_rvalid});
            else n_pass++;
            tick();
        end
        rst_n = 1'b1;
        set_inputs(1'b1, 1'b0, 12'h040, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        n_checks++;
        if ({c_p_gnt, c_g_gnt, c_g_rvalid} !== 3'b100)
            $display("FAIL post_reset_grant: got p,g,grv=%b want 100", {c_p_gnt, c_g_gnt, c_g_rvalid});
        else n_pass++;
        tick();
        set_inputs(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        n_checks++;
        if ({c_p_rvalid, c_g_rvalid} !== 2'b00)
            $display("FAIL post_reset_early: got prv,grv=%b want 00", {c_p_rvalid, c_g_rvalid});
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if ({c_p_rvalid, c_g_rvalid, c_p_rdata} !== {2'b10, 32'h44})
            $display("FAIL post_reset_return: got prv=%b grv=%b data=%h want 1 0 00000044",
                     c_p_rvalid, c_g_rvalid, c_p_rdata);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        set_inputs(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h000, 32'h0);
        mem_a[12'h010] = 32'h11;
        mem_a[12'h020] = 32'h22;
        mem_b[12'h3FF] = 32'hCAFE_0000;
        mem_c[12'h040] = 32'h44;
        test_reset();
        test_write_read();
        test_contention();
        test_alternate();
        test_g_write_disabled();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
